dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port round-robin arbiter and init sequencer in front of the single-port 1K×32 data memory. It shares the memory between the pipeline MEM stage (port 0) and the debug/DMA loader (port 1) using a valid/ready request handshake and a registered response. After reset it sweeps the whole memory to zero before accepting any traffic. The memory itself keeps combinational read and a synchronous write on `clk`.

## Interface
Parameters:
- `DATA_W`, 32, data width.
- `ADDR_W`, 32, request address width; the address is a word index.
- `DEPTH`, 1024, number of memory words.
- `INIT_CLEAR`, 1, 1 = zero-fill the memory after reset; 0 = go straight to IDLE.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid[1:0]` in 2: per-port request valid.
- `req_ready[1:0]` out 2: per-port accept; a transfer happens when valid && ready.
- `req_we[1:0]` in 2: 1 = write, 0 = read.
- `req_addr0`, `req_addr1` in ADDR_W: word address.
- `req_wdata0`, `req_wdata1` in DATA_W: write data.
- `rsp_valid[1:0]` out 2: one-cycle response pulse to the port that was accepted.
- `rsp_rdata` out DATA_W: registered read data; 0 for writes.
- `rsp_err` out 1: accepted address was ≥ DEPTH.
- `mem_we` out 1, `mem_addr` out $clog2(DEPTH), `mem_wdata` out DATA_W: memory write/read port.
- `mem_rdata` in DATA_W: combinational memory read data.
- `init_done` out 1: high once the clear sweep is finished.

## Operation
- States: CLEAR, IDLE.
  - Reset enters CLEAR if INIT_CLEAR=1, otherwise IDLE.
- CLEAR:
  - Drives `mem_we`=1, `mem_wdata`=0, `mem_addr`=`clr_cnt`.
  - `clr_cnt` runs 0..DEPTH-1, one word per cycle.
  - When the word at DEPTH-1 is written, the next state is IDLE and `init_done` goes to 1.
  - `req_ready`=0 throughout.
- IDLE arbitration, combinational each cycle:
  - Only one valid: that port is granted.
  - Both valid: the port not granted last is granted.
  - The pointer resets to "last = port 1", so port 0 wins the first tie.
  - `req_ready[g]`=1 for the granted port only.
  - The pointer updates only on an accepted transfer.
- Accepted request:
  - `mem_addr` = req_addr[log2 DEPTH-1:0].
  - `mem_we` = req_we && in_range; `mem_wdata` = req_wdata.
- Response register, one cycle after acceptance:
  - `rsp_valid[g]` pulses 1.
  - `rsp_rdata` = `mem_rdata` sampled at acceptance for an in-range read, else 0.
  - `rsp_err` = !in_range.
- Out-of-range writes are dropped; the memory is unchanged.
- A losing port holds its request. It is served on the next cycle if the winner deasserts, or on the following tie by round-robin, so starvation is bounded at one cycle.
- No response backpressure: requesters must always sink `rsp_valid`.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `mem_we`=0, `init_done`=0, `clr_cnt`=0, pointer = port 1.
- Clear takes exactly DEPTH cycles after reset release.
  - `init_done` rises on the edge after the last clear write.
  - The first request can be accepted in that same cycle.
- Throughput: one transfer per cycle, total across both ports.
- Latency: request accepted at edge N gives `rsp_valid` high during cycle N+1.
- Write then read to the same address on consecutive cycles, from either port: the read returns the new data.
- Reset asserted mid-CLEAR: the sweep restarts from 0 after release.
- Reset asserted mid-response: `rsp_valid` clears immediately (asynchronously).
- `rsp_valid` is never high on both ports in the same cycle.

## Structure
- Package `dmem_arb_pkg`: state enum {CLEAR, IDLE}, `NUM_PORTS`=2, default DEPTH/DATA_W constants, port index constants `PORT_MEM`=0 and `PORT_DBG`=1.
- Sub-module `rr_arbiter2`:
  - Inputs: req[1:0], accept.
  - Outputs: one-hot grant[1:0].
  - Holds the last-grant pointer, flopped on `clk`/`rst_n`.
- Top level: FSM, clear counter, address range check, memory mux, response register.

## Test plan
- Reset release with INIT_CLEAR=1, memory preloaded with nonzero data → `init_done` rises after exactly 1024 cycles. A port-0 read of address 32 then returns 0 with `rsp_valid[0]` one cycle later.
- Port 0 writes 0x55555555 to address 32, then reads it on the next cycle → read response `rsp_rdata`=0x55555555, `rsp_err`=0.
- Both ports hold valid reads for 4 cycles → grants alternate 0,1,0,1. Each `rsp_valid` pulse matches its port, and the two are never high together.
- Port 1 writes address 1024 → `rsp_err`=1, `rsp_rdata`=0, and a read of address 0 shows unchanged contents.
- `rst_n` pulsed low at clear word 500 → `init_done` stays 0 and the sweep restarts at 0, completing 1024 cycles after release. Pulsing `rst_n` during a pending response → `rsp_valid` drops immediately.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned DEPTH_DEF  = 1024;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned PORT_MEM   = 0;
  localparam int unsigned PORT_DBG   = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; pointer advances only on an accepted grant.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 accept,
  output logic [NUM_PORTS-1:0] grant
);

  // 1 when the debug port held the most recent grant
  logic last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[PORT_DBG];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin front end for the single-port data memory, with a post-reset
// zero-fill sweep before any request is accepted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter bit          INIT_CLEAR = 1'b1,
  localparam int unsigned MA_W      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [NUM_PORTS-1:0] req_we,
  input  logic [ADDR_W-1:0]    req_addr0,
  input  logic [ADDR_W-1:0]    req_addr1,
  input  logic [DATA_W-1:0]    req_wdata0,
  input  logic [DATA_W-1:0]    req_wdata1,
  output logic [NUM_PORTS-1:0] rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_we,
  output logic [MA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 init_done
);

  localparam logic [0:0]        ST_CLEAR  = CLEAR;
  localparam logic [0:0]        ST_IDLE   = IDLE;
  localparam logic [MA_W-1:0]   LAST_WORD = MA_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  logic [0:0]           state, state_next;
  logic [MA_W-1:0]      clr_cnt, clr_next;
  logic [NUM_PORTS-1:0] grant;
  logic                 idle, accept, sel, sel_we, in_range;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  assign idle = (state == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid & {NUM_PORTS{idle}}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept    = |grant;
  assign req_ready = grant;

  // Steer the granted port onto the memory side
  assign sel       = grant[PORT_DBG];
  assign sel_addr  = sel ? req_addr1  : req_addr0;
  assign sel_wdata = sel ? req_wdata1 : req_wdata0;
  assign sel_we    = req_we[sel];
  assign in_range  = (sel_addr < DEPTH_A);

  always_comb begin
    state_next = state;
    clr_next   = clr_cnt;
    mem_we     = 1'b0;
    mem_addr   = sel_addr[MA_W-1:0];
    mem_wdata  = sel_wdata;
    case (state)
      ST_CLEAR: begin
        // Sweep writes are held off while reset is asserted
        mem_we    = rst_n;
        mem_addr  = clr_cnt;
        mem_wdata = '0;
        clr_next  = clr_cnt + MA_W'(1);
        if (clr_cnt == LAST_WORD) begin
          state_next = ST_IDLE;
          clr_next   = '0;
        end
      end
      default: begin
        mem_we = accept & sel_we & in_range;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_next;
      init_done <= (state_next == ST_IDLE);
    end
  end

  // Response register: one-cycle pulse back to the accepted port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= grant;
      rsp_rdata <= (accept && !sel_we && in_range) ? mem_rdata : '0;
      rsp_err   <= accept && !in_range;
    end
  end

endmodule
